// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder datapath: controller state
// encoding, default operand width and the matching result width.
package serial_adder_pkg;

  // Operand feeder controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } tx_state_t;

  // Default operand width in bits
  localparam int DEFAULT_WIDTH = 8;

  // The collector keeps one extra bit for the final carry / no-borrow flag
  localparam int RESULT_WIDTH = DEFAULT_WIDTH + 1;

  // Result width for an arbitrary operand width
  function automatic int result_width(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/piso_shift_r.sv
// Parallel-in / serial-out right shifter. A load captures the parallel word;
// each shift moves it one place towards bit 0 with zero fill, so the serial
// output always presents the current LSB. Load has priority over shift.
module piso_shift_r #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         serial_o
);

  logic [W-1:0] shift_reg;

  // Capture on load, otherwise shift right with zero fill
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      shift_reg <= '0;
    end else if (load_i) begin
      shift_reg <= data_i;
    end else if (shift_i) begin
      shift_reg <= {1'b0, shift_reg[W-1:1]};
    end
  end

  assign serial_o = shift_reg[0];

endmodule

// File: rtl/serial_operand_tx.sv
// Parallel-to-serial operand feeder for the bit-serial adder.
// Streams two WIDTH-bit operands LSB first, then adds one zero "flush"
// bit pair so the adder's carry lands in the collector as bit WIDTH.
// Optional subtract mode is built when SERIAL_TX_SUB_EN is defined: the
// sub_i port appears, B is inverted during SHIFT and the carry starts at 1.
module serial_operand_tx
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
`ifdef SERIAL_TX_SUB_EN
  input  logic             sub_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             a_bit_o,
  output logic             b_bit_o,
  output logic             carry_clr_o,
  output logic             carry_init_o,
  output logic             shift_en_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  tx_state_t        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ready_reg;
  logic             shift_en_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             shifting_reg;   // high only in SHIFT: gates the data bits

  logic             accept;
  logic             a_ser;
  logic             b_ser;
  logic             b_inv;

  assign accept = start_i & ready_reg;

  // Controller: state, bit counter and all registered status outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      ready_reg    <= 1'b1;
      shift_en_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      shifting_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            state_reg    <= ST_SHIFT;
            cnt_reg      <= '0;
            ready_reg    <= 1'b0;
            shift_en_reg <= 1'b1;
            busy_reg     <= 1'b1;
            shifting_reg <= 1'b1;
          end
        end
        ST_SHIFT: begin
          // Stop counting on the last bit so the counter never wraps
          if (cnt_reg == LAST_BIT) begin
            state_reg    <= ST_FLUSH;
            shifting_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_FLUSH: begin
          state_reg    <= ST_DONE;
          shift_en_reg <= 1'b0;
          busy_reg     <= 1'b0;
          done_reg     <= 1'b1;
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
        end
        default: begin
          state_reg    <= ST_IDLE;
          ready_reg    <= 1'b1;
          shift_en_reg <= 1'b0;
          busy_reg     <= 1'b0;
          done_reg     <= 1'b0;
          shifting_reg <= 1'b0;
        end
      endcase
    end
  end

  // Operand shift registers: loaded on acceptance, shifted once per SHIFT cycle
  piso_shift_r #(.W(WIDTH)) u_piso_a (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (accept),
    .shift_i  (shifting_reg),
    .data_i   (a_i),
    .serial_o (a_ser)
  );

  piso_shift_r #(.W(WIDTH)) u_piso_b (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (accept),
    .shift_i  (shifting_reg),
    .data_i   (b_i),
    .serial_o (b_ser)
  );

`ifdef SERIAL_TX_SUB_EN
  logic sub_reg;

  // Remember the operation mode for the whole transfer
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sub_reg <= 1'b0;
    end else if (accept) begin
      sub_reg <= sub_i;
    end
  end

  // A - B = A + ~B + 1: invert B only while data bits flow, seed carry with 1
  assign b_inv        = sub_reg & shifting_reg;
  assign carry_init_o = accept & sub_i;
`else
  assign b_inv        = 1'b0;
  assign carry_init_o = 1'b0;
`endif

  // Data bits are forced to zero outside SHIFT, which makes FLUSH a pure
  // carry-out cycle regardless of mode
  assign a_bit_o     = shifting_reg & a_ser;
  assign b_bit_o     = shifting_reg & (b_ser ^ b_inv);
  assign carry_clr_o = accept;
  assign ready_o     = ready_reg;
  assign shift_en_o  = shift_en_reg;
  assign busy_o      = busy_reg;
  assign done_o      = done_reg;

endmodule

// File: tb/tb_serial_operand_tx.sv
// Directed testbench for serial_operand_tx with a downstream bit-serial adder
// and right-shifting sum collector. Build with SERIAL_TX_SUB_EN defined to
// exercise subtract mode as well.
module tb_serial_operand_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
`ifdef SERIAL_TX_SUB_EN
  logic       sub_i;
`endif
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic       ready_o;
  logic       a_bit_o;
  logic       b_bit_o;
  logic       carry_clr_o;
  logic       carry_init_o;
  logic       shift_en_o;
  logic       busy_o;
  logic       done_o;

  int checks   = 0;
  int failures = 0;

  serial_operand_tx #(.WIDTH(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .start_i      (start_i),
`ifdef SERIAL_TX_SUB_EN
    .sub_i        (sub_i),
`endif
    .a_i          (a_i),
    .b_i          (b_i),
    .ready_o      (ready_o),
    .a_bit_o      (a_bit_o),
    .b_bit_o      (b_bit_o),
    .carry_clr_o  (carry_clr_o),
    .carry_init_o (carry_init_o),
    .shift_en_o   (shift_en_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  // Downstream environment: serial full adder plus 9-bit sum collector
  logic       carry_q;
  logic [8:0] coll;
  logic       sum_bit;
  assign sum_bit = a_bit_o ^ b_bit_o ^ carry_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      coll    <= '0;
    end else begin
      if (carry_clr_o)
        carry_q <= carry_init_o;
      else if (shift_en_o)
        carry_q <= (a_bit_o & b_bit_o) | (a_bit_o & carry_q) | (b_bit_o & carry_q);
      if (shift_en_o)
        coll <= {sum_bit, coll[8:1]};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation: checks acceptance, serial A bits, shift_en length,
  // done pulse and collector result. disturb=1 changes inputs mid-SHIFT.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input logic [8:0] exp, input int disturb, input string tag);
    int         n;
    int         guard;
    logic [8:0] seq;
    logic       exp_init;
    exp_init = sub;
`ifndef SERIAL_TX_SUB_EN
    exp_init = 1'b0;
`endif
    guard = 0;
    while (!ready_o && guard < 50) begin
      tick();
      guard++;
    end
    chk({tag, "_ready"}, 32'(ready_o), 32'd1);
    a_i     = a;
    b_i     = b;
    start_i = 1'b1;
`ifdef SERIAL_TX_SUB_EN
    sub_i   = sub;
`endif
    #1;
    chk({tag, "_carry_clr"}, 32'(carry_clr_o), 32'd1);
    chk({tag, "_carry_init"}, 32'(carry_init_o), 32'(exp_init));
    tick();
    start_i = 1'b0;
    chk({tag, "_busy"}, 32'(busy_o), 32'd1);
    chk({tag, "_carry_clr_low"}, 32'(carry_clr_o), 32'd0);
    n   = 0;
    seq = '0;
    while (shift_en_o && n < 20) begin
      if (n < 9) seq[n] = a_bit_o;
      if (disturb != 0 && n == 3) begin
        a_i     = 8'hFF;
        b_i     = 8'hFF;
        start_i = 1'b1;
      end
      if (disturb != 0 && n == 4) start_i = 1'b0;
      tick();
      n++;
    end
    chk({tag, "_shift_cycles"}, 32'(n), 32'd9);
    chk({tag, "_a_bits"}, 32'(seq), 32'({1'b0, a}));
    chk({tag, "_done"}, 32'(done_o), 32'd1);
    chk({tag, "_result"}, 32'(coll), 32'(exp));
    chk({tag, "_busy_done"}, 32'(busy_o), 32'd0);
    chk({tag, "_ready_done"}, 32'(ready_o), 32'd0);
    $display("op %s a=0x%02h b=0x%02h sub=%0d result=0x%03h", tag, a, b, sub, coll);
    tick();
    chk({tag, "_done_pulse"}, 32'(done_o), 32'd0);
    chk({tag, "_ready_after"}, 32'(ready_o), 32'd1);
    chk({tag, "_shift_after"}, 32'(shift_en_o), 32'd0);
  endtask

  initial begin
    int n_shift;
    int n_done;
    int n_ready;
    int guard;

    rst_n   = 1'b0;
    start_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
`ifdef SERIAL_TX_SUB_EN
    sub_i   = 1'b0;
`endif
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_ready", 32'(ready_o), 32'd1);
    chk("reset_outs", 32'({shift_en_o, busy_o, done_o, a_bit_o, b_bit_o, carry_clr_o}), 32'd0);
    $display("op reset ready=%0d busy=%0d", ready_o, busy_o);

    run_op(8'hA5, 8'h3C, 1'b0, 9'h0E1, 0, "add_a5_3c");
    run_op(8'hFF, 8'h01, 1'b0, 9'h100, 0, "add_ff_01");
    run_op(8'h12, 8'h34, 1'b0, 9'h046, 1, "ignore_mid");

    // Continuous start: each period is 9 shift + 1 done + 1 idle cycles
    a_i     = 8'h01;
    b_i     = 8'h01;
    start_i = 1'b1;
    tick();
    n_shift = 0;
    n_done  = 0;
    n_ready = 0;
    for (int i = 0; i < 33; i++) begin
      if (shift_en_o) n_shift++;
      if (done_o) n_done++;
      if (ready_o) n_ready++;
      if (i == 9) chk("b2b_result", 32'(coll), 32'h002);
      if (i < 32) tick();
    end
    start_i = 1'b0;
    chk("b2b_shift_cycles", 32'(n_shift), 32'd27);
    chk("b2b_done_cycles", 32'(n_done), 32'd3);
    chk("b2b_ready_cycles", 32'(n_ready), 32'd3);
    $display("op back_to_back shift=%0d done=%0d ready=%0d", n_shift, n_done, n_ready);
    guard = 0;
    while (!ready_o && guard < 50) begin
      tick();
      guard++;
    end

    // Reset mid-SHIFT: outputs must drop immediately, no done afterwards
    a_i     = 8'hFF;
    b_i     = 8'hFF;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (3) tick();
    chk("abort_busy_before", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(ready_o), 32'd1);
    chk("abort_outs", 32'({shift_en_o, busy_o, done_o, a_bit_o, b_bit_o}), 32'd0);
    tick();
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_o || shift_en_o) n_done++;
      tick();
    end
    chk("abort_no_activity", 32'(n_done), 32'd0);
    $display("op reset_abort ready=%0d busy=%0d", ready_o, busy_o);

    run_op(8'h80, 8'h81, 1'b0, 9'h101, 0, "fresh_after_abort");

`ifdef SERIAL_TX_SUB_EN
    run_op(8'h05, 8'h03, 1'b1, 9'h102, 0, "sub_05_03");
    run_op(8'h03, 8'h05, 1'b1, 9'h0FE, 0, "sub_03_05");
    run_op(8'h03, 8'h05, 1'b0, 9'h008, 0, "add_after_sub");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
